// File: rtl/datapath_sequencer_if.sv
// Instruction handshake, datapath status and datapath control bundle for datapath_sequencer.
interface datapath_sequencer_if;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned K_W     = 64;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned FS_W    = 5;
    localparam int unsigned FLAG_W  = 4;

    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_ready;
    logic [FLAG_W-1:0]  status;
    logic [K_W-1:0]     k;
    logic [REG_W-1:0]   DA;
    logic [REG_W-1:0]   SA;
    logic [REG_W-1:0]   SB;
    logic [FS_W-1:0]    FS;
    logic               dataMux;
    logic               regW;
    logic               ramW;
    logic               R;
    logic               Bsel;
    logic               done;
    logic               illegal;
    logic [FLAG_W-1:0]  flags;

    modport master (
        output instr_valid, instr, status,
        input  instr_ready, k, DA, SA, SB, FS, dataMux, regW, ramW, R, Bsel,
               done, illegal, flags
    );

    modport slave (
        input  instr_valid, instr, status,
        output instr_ready, k, DA, SA, SB, FS, dataMux, regW, ramW, R, Bsel,
               done, illegal, flags
    );
endinterface

// File: rtl/datapath_sequencer.sv
// Multi-cycle instruction sequencer: accepts one instruction at a time, decodes it and
// drives registered datapath controls through EXEC/MEM, retiring with a one-cycle done pulse.
module datapath_sequencer (
    input  logic                clock,
    input  logic                reset_n,
    datapath_sequencer_if.slave bus
);
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned K_W     = 64;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned FS_W    = 5;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned ADDR_W  = 9;

    localparam logic [REG_W-1:0] XZR    = 5'd31;
    localparam logic [FS_W-1:0]  FS_AND = 5'b00000;
    localparam logic [FS_W-1:0]  FS_ORR = 5'b00100;
    localparam logic [FS_W-1:0]  FS_ADD = 5'b01000;
    localparam logic [FS_W-1:0]  FS_SUB = 5'b01011;
    localparam logic [FS_W-1:0]  FS_LSL = 5'b10000;
    localparam logic [FS_W-1:0]  FS_LSR = 5'b10100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_DONE
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR, OP_LSL, OP_LSR,
        OP_ADDI, OP_SUBI, OP_LDUR, OP_STUR, OP_ILL
    } op_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [FLAG_W-1:0]  flags_q, flags_d;
    logic               ready_q, ready_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [REG_W-1:0]   da_q, da_d;
    logic [REG_W-1:0]   sa_q, sa_d;
    logic [REG_W-1:0]   sb_q, sb_d;
    logic [FS_W-1:0]    fs_q, fs_d;
    logic               datamux_q, datamux_d;
    logic               regw_q, regw_d;
    logic               ramw_q, ramw_d;
    logic               r_q, r_d;
    logic               bsel_q, bsel_d;
    logic               done_q, done_d;
    logic               illegal_q, illegal_d;

    op_e                op_c;
    logic [FS_W-1:0]    fs_c;
    logic [REG_W-1:0]   rd_c, rn_c, rm_c;
    logic [K_W-1:0]     shamt_k_c, imm_k_c, addr_k_c;

    // Opcode classification and operand field extraction from the latched instruction.
    always_comb begin
        rd_c      = instr_q[4:0];
        rn_c      = instr_q[9:5];
        rm_c      = instr_q[20:16];
        shamt_k_c = K_W'(instr_q[15:10]);
        imm_k_c   = K_W'(instr_q[21:10]);
        addr_k_c  = {{(K_W-ADDR_W){instr_q[20]}}, instr_q[20:12]};
        op_c      = OP_ILL;
        fs_c      = FS_ADD;
        case (instr_q[31:21])
            11'b10001011000: op_c = OP_ADD;
            11'b10101011000: op_c = OP_ADDS;
            11'b11001011000: begin op_c = OP_SUB;  fs_c = FS_SUB; end
            11'b11101011000: begin op_c = OP_SUBS; fs_c = FS_SUB; end
            11'b10001010000: begin op_c = OP_AND;  fs_c = FS_AND; end
            11'b10101010000: begin op_c = OP_ORR;  fs_c = FS_ORR; end
            11'b11010011011: begin op_c = OP_LSL;  fs_c = FS_LSL; end
            11'b11010011010: begin op_c = OP_LSR;  fs_c = FS_LSR; end
            11'b11111000010: op_c = OP_LDUR;
            11'b11111000000: op_c = OP_STUR;
            default: begin
                if (instr_q[31:22] == 10'b1001000100) begin
                    op_c = OP_ADDI;
                end else if (instr_q[31:22] == 10'b1101000100) begin
                    op_c = OP_SUBI;
                    fs_c = FS_SUB;
                end
            end
        endcase
    end

    // Next state plus next values of every registered output, decoded from the state being entered.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        flags_d   = flags_q;
        ready_d   = 1'b0;
        k_d       = '0;
        da_d      = '0;
        sa_d      = '0;
        sb_d      = '0;
        fs_d      = '0;
        datamux_d = 1'b0;
        regw_d    = 1'b0;
        ramw_d    = 1'b0;
        r_d       = 1'b0;
        bsel_d    = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid && ready_q) begin
                    instr_d = bus.instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op_c == OP_ILL) begin
                    illegal_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = (op_c == OP_LDUR) ? S_MEM : S_DONE;
                if (op_c == OP_ADDS || op_c == OP_SUBS) begin
                    flags_d = bus.status;
                end
            end
            S_MEM:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);

        if (state_d == S_EXEC || state_d == S_MEM) begin
            fs_d = fs_c;
            sa_d = rn_c;
            case (op_c)
                OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR: begin
                    sb_d   = rm_c;
                    da_d   = rd_c;
                    regw_d = 1'b1;
                end
                OP_LSL, OP_LSR: begin
                    sb_d   = rm_c;
                    da_d   = rd_c;
                    k_d    = shamt_k_c;
                    bsel_d = 1'b1;
                    regw_d = 1'b1;
                end
                OP_ADDI, OP_SUBI: begin
                    da_d   = rd_c;
                    k_d    = imm_k_c;
                    bsel_d = 1'b1;
                    regw_d = 1'b1;
                end
                OP_LDUR: begin
                    // Address stays on the ALU through MEM while the RAM read data is written back.
                    da_d   = rd_c;
                    k_d    = addr_k_c;
                    bsel_d = 1'b1;
                    r_d    = 1'b1;
                    if (state_d == S_MEM) begin
                        datamux_d = 1'b1;
                        regw_d    = 1'b1;
                    end
                end
                OP_STUR: begin
                    sb_d   = rd_c;
                    k_d    = addr_k_c;
                    bsel_d = 1'b1;
                    ramw_d = 1'b1;
                end
                default: ;
            endcase
            if (da_d == XZR) begin
                regw_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            flags_q   <= '0;
            ready_q   <= 1'b0;
            k_q       <= '0;
            da_q      <= '0;
            sa_q      <= '0;
            sb_q      <= '0;
            fs_q      <= '0;
            datamux_q <= 1'b0;
            regw_q    <= 1'b0;
            ramw_q    <= 1'b0;
            r_q       <= 1'b0;
            bsel_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            flags_q   <= flags_d;
            ready_q   <= ready_d;
            k_q       <= k_d;
            da_q      <= da_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            fs_q      <= fs_d;
            datamux_q <= datamux_d;
            regw_q    <= regw_d;
            ramw_q    <= ramw_d;
            r_q       <= r_d;
            bsel_q    <= bsel_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.k           = k_q;
    assign bus.DA          = da_q;
    assign bus.SA          = sa_q;
    assign bus.SB          = sb_q;
    assign bus.FS          = fs_q;
    assign bus.dataMux     = datamux_q;
    assign bus.regW        = regw_q;
    assign bus.ramW        = ramw_q;
    assign bus.R           = r_q;
    assign bus.Bsel        = bsel_q;
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;
    assign bus.flags       = flags_q;
endmodule

// File: tb/tb_datapath_sequencer.sv
// Randomized and directed bench for datapath_sequencer against a per-instruction cycle model.
module tb_datapath_sequencer;
    typedef struct packed {
        logic        ready;
        logic [63:0] k;
        logic [4:0]  da;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [4:0]  fs;
        logic        dmux;
        logic        regw;
        logic        ramw;
        logic        r;
        logic        bsel;
        logic        done;
        logic        illegal;
        logic [3:0]  flags;
    } out_t;

    logic clock = 1'b0;
    logic reset_n;
    datapath_sequencer_if bus ();
    datapath_sequencer dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    always #5 clock = ~clock;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] mflags;
    out_t       exp_a[5];
    out_t       got_a[5];

    function automatic out_t snap();
        out_t s;
        s.ready   = bus.instr_ready;
        s.k       = bus.k;
        s.da      = bus.DA;
        s.sa      = bus.SA;
        s.sb      = bus.SB;
        s.fs      = bus.FS;
        s.dmux    = bus.dataMux;
        s.regw    = bus.regW;
        s.ramw    = bus.ramW;
        s.r       = bus.R;
        s.bsel    = bus.Bsel;
        s.done    = bus.done;
        s.illegal = bus.illegal;
        s.flags   = bus.flags;
        return s;
    endfunction

    // Expected outputs in the five cycles following the accept edge; updates model flags.
    function automatic void model(input logic [31:0] ins, input logic [3:0] st);
        out_t idle, e, d;
        logic legal, is_ld, is_st, sets, uses_rm, bs;
        logic [4:0] fs, rd, rn, rm;
        logic [63:0] kv;
        int a9;
        rd = ins[4:0]; rn = ins[9:5]; rm = ins[20:16];
        legal = 1'b1; is_ld = 1'b0; is_st = 1'b0; sets = 1'b0; uses_rm = 1'b1;
        bs = 1'b0; kv = '0; fs = 5'b01000;
        a9 = int'(ins[20:12]);
        if (a9 > 255) a9 = a9 - 512;
        case (ins[31:21])
            11'b10001011000: ;
            11'b10101011000: sets = 1'b1;
            11'b11001011000: fs = 5'b01011;
            11'b11101011000: begin fs = 5'b01011; sets = 1'b1; end
            11'b10001010000: fs = 5'b00000;
            11'b10101010000: fs = 5'b00100;
            11'b11010011011: begin fs = 5'b10000; kv = 64'(ins[15:10]); bs = 1'b1; end
            11'b11010011010: begin fs = 5'b10100; kv = 64'(ins[15:10]); bs = 1'b1; end
            11'b11111000010: begin is_ld = 1'b1; kv = 64'(longint'(a9)); bs = 1'b1; end
            11'b11111000000: begin is_st = 1'b1; kv = 64'(longint'(a9)); bs = 1'b1; end
            default: begin
                if (ins[31:22] == 10'b1001000100) begin
                    kv = 64'(ins[21:10]); bs = 1'b1; uses_rm = 1'b0;
                end else if (ins[31:22] == 10'b1101000100) begin
                    kv = 64'(ins[21:10]); bs = 1'b1; uses_rm = 1'b0; fs = 5'b01011;
                end else begin
                    legal = 1'b0;
                end
            end
        endcase
        idle = '0; idle.ready = 1'b1; idle.flags = mflags;
        exp_a[0] = '0; exp_a[0].flags = mflags;
        if (!legal) begin
            exp_a[1] = idle; exp_a[1].illegal = 1'b1;
            exp_a[2] = idle; exp_a[3] = idle; exp_a[4] = idle;
            return;
        end
        e = '0; e.flags = mflags; e.sa = rn; e.k = kv; e.fs = fs; e.bsel = bs;
        if (is_st) begin
            e.sb = rd; e.ramw = 1'b1;
        end else if (is_ld) begin
            e.da = rd; e.r = 1'b1;
        end else begin
            e.da = rd; e.sb = uses_rm ? rm : 5'd0; e.regw = (rd != 5'd31);
        end
        exp_a[1] = e;
        if (sets) mflags = st;
        idle.flags = mflags;
        d = '0; d.done = 1'b1; d.flags = mflags;
        if (is_ld) begin
            e.flags = mflags; e.dmux = 1'b1; e.regw = (rd != 5'd31);
            exp_a[2] = e; exp_a[3] = d; exp_a[4] = idle;
        end else begin
            exp_a[2] = d; exp_a[3] = idle; exp_a[4] = idle;
        end
    endfunction

    // Waits for ready, presents one instruction and records five post-accept cycles.
    task automatic issue(input logic [31:0] ins, input logic [3:0] st, input bit hold, input string tag);
        int n = 0;
        while (bus.instr_ready !== 1'b1 && n < 20) begin
            @(posedge clock); #1; n++;
        end
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_timeout got=%b exp=1", tag, bus.instr_ready);
        end
        bus.instr_valid = 1'b1; bus.instr = ins; bus.status = st;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            got_a[i] = snap();
            if (i == 0 && !hold) begin bus.instr_valid = 1'b0; bus.instr = $urandom; end
            if (i == 2 && hold) bus.instr_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        out_t e;
        reset_n = 1'b0; bus.instr_valid = 1'b0; bus.instr = '0; bus.status = '0;
        mflags = 4'd0;
        #3;
        checks++;
        if (snap() !== out_t'(0)) begin
            failures++; $display("FAIL reset_async got=%h exp=%h", snap(), out_t'(0));
        end
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (snap() !== out_t'(0)) begin
            failures++; $display("FAIL reset_hold got=%h exp=%h", snap(), out_t'(0));
        end
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        e = '0; e.ready = 1'b1;
        checks++;
        if (snap() !== e) begin
            failures++; $display("FAIL reset_release got=%h exp=%h", snap(), e);
        end
    endtask

    task automatic test_addi();
        model(32'h910017E1, 4'hA);
        issue(32'h910017E1, 4'hA, 1'b0, "addi");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin
                failures++; $display("FAIL addi cyc%0d got=%h exp=%h", i, got_a[i], exp_a[i]);
            end
        end
        checks++;
        if ({got_a[1].k, got_a[1].sa, got_a[1].da, got_a[1].bsel, got_a[1].fs, got_a[1].regw, got_a[2].done}
            !== {64'd5, 5'd31, 5'd1, 1'b1, 5'b01000, 1'b1, 1'b1}) begin
            failures++; $display("FAIL addi_fields got k=%0d sa=%0d da=%0d fs=%b done=%b exp k=5 sa=31 da=1 fs=01000 done=1",
                                 got_a[1].k, got_a[1].sa, got_a[1].da, got_a[1].fs, got_a[2].done);
        end
    endtask

    task automatic test_subs_flags();
        logic [31:0] subs, add;
        subs = {11'b11101011000, 5'd2, 6'd0, 5'd1, 5'd3};
        add  = {11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd5};
        model(subs, 4'b0001);
        issue(subs, 4'b0001, 1'b0, "subs");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin
                failures++; $display("FAIL subs cyc%0d got=%h exp=%h", i, got_a[i], exp_a[i]);
            end
        end
        checks++;
        if ({got_a[1].fs, got_a[1].sb, got_a[1].regw, got_a[3].flags} !== {5'b01011, 5'd2, 1'b1, 4'b0001}) begin
            failures++; $display("FAIL subs_fields got fs=%b sb=%0d regw=%b flags=%b exp fs=01011 sb=2 regw=1 flags=0001",
                                 got_a[1].fs, got_a[1].sb, got_a[1].regw, got_a[3].flags);
        end
        model(add, 4'b1110);
        issue(add, 4'b1110, 1'b0, "add_after_subs");
        checks++;
        if (got_a[4].flags !== 4'b0001) begin
            failures++; $display("FAIL add_keeps_flags got=%b exp=0001", got_a[4].flags);
        end
    endtask

    task automatic test_ldur();
        logic [31:0] ld;
        ld = {11'b11111000010, 9'h1F8, 2'b00, 5'd1, 5'd4};
        model(ld, 4'h3);
        issue(ld, 4'h3, 1'b0, "ldur");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin
                failures++; $display("FAIL ldur cyc%0d got=%h exp=%h", i, got_a[i], exp_a[i]);
            end
        end
        checks++;
        if ({got_a[1].k, got_a[1].r, got_a[1].regw, got_a[2].dmux, got_a[2].da, got_a[2].regw, got_a[2].done, got_a[3].done}
            !== {64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1}) begin
            failures++; $display("FAIL ldur_fields got k=%h r=%b mem_dmux=%b mem_da=%0d done3=%b exp k=fffffffffffffff8 r=1 mem_dmux=1 mem_da=4 done3=1",
                                 got_a[1].k, got_a[1].r, got_a[2].dmux, got_a[2].da, got_a[3].done);
        end
    endtask

    task automatic test_stur_illegal();
        logic [31:0] st;
        int nramw, nill, nwr;
        st = {11'b11111000000, 9'd0, 2'b00, 5'd1, 5'd2};
        model(st, 4'h0);
        issue(st, 4'h0, 1'b0, "stur");
        nramw = 0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin
                failures++; $display("FAIL stur cyc%0d got=%h exp=%h", i, got_a[i], exp_a[i]);
            end
            nramw += int'(got_a[i].ramw);
        end
        checks++;
        if (nramw !== 1 || got_a[1].sb !== 5'd2) begin
            failures++; $display("FAIL stur_ramw got cycles=%0d sb=%0d exp cycles=1 sb=2", nramw, got_a[1].sb);
        end
        model(32'hFFFF_FFFF, 4'h0);
        issue(32'hFFFF_FFFF, 4'h0, 1'b0, "illegal");
        nill = 0; nwr = 0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin
                failures++; $display("FAIL illegal cyc%0d got=%h exp=%h", i, got_a[i], exp_a[i]);
            end
            nill += int'(got_a[i].illegal);
            nwr  += int'(got_a[i].regw) + int'(got_a[i].ramw) + int'(got_a[i].r);
        end
        checks++;
        if (nill !== 1 || nwr !== 0) begin
            failures++; $display("FAIL illegal_pulse got pulses=%0d writes=%0d exp pulses=1 writes=0", nill, nwr);
        end
    endtask

    task automatic test_xzr_hold();
        logic [31:0] ins;
        int nreg;
        ins = {11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd31};
        model(ins, 4'h0);
        issue(ins, 4'h0, 1'b1, "xzr_hold");
        nreg = 0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin
                failures++; $display("FAIL xzr_hold cyc%0d got=%h exp=%h", i, got_a[i], exp_a[i]);
            end
            nreg += int'(got_a[i].regw);
        end
        checks++;
        if (nreg !== 0 || got_a[2].done !== 1'b1) begin
            failures++; $display("FAIL xzr_regw got regw_cycles=%0d done=%b exp regw_cycles=0 done=1", nreg, got_a[2].done);
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [31:0] ld;
        out_t e;
        int n = 0;
        ld = {11'b11111000010, 9'd16, 2'b00, 5'd7, 5'd9};
        while (bus.instr_ready !== 1'b1 && n < 20) begin
            @(posedge clock); #1; n++;
        end
        bus.instr_valid = 1'b1; bus.instr = ld; bus.status = 4'($urandom);
        @(posedge clock); #1; bus.instr_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        checks++;
        if ({bus.regW, bus.R} !== 2'b11) begin
            failures++; $display("FAIL rst_mem_pre got regw=%b r=%b exp regw=1 r=1", bus.regW, bus.R);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.regW, bus.R, bus.ramW, bus.done} !== 4'b0000) begin
            failures++; $display("FAIL rst_mem_drop got regw=%b r=%b ramw=%b done=%b exp 0000", bus.regW, bus.R, bus.ramW, bus.done);
        end
        repeat (2) begin
            @(posedge clock); #1;
            checks++;
            if (bus.done !== 1'b0) begin
                failures++; $display("FAIL rst_mem_done got=%b exp=0", bus.done);
            end
        end
        @(negedge clock); reset_n = 1'b1; mflags = 4'd0;
        @(posedge clock); #1;
        e = '0; e.ready = 1'b1;
        checks++;
        if (snap() !== e) begin
            failures++; $display("FAIL rst_mem_release got=%h exp=%h", snap(), e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ia, ib;
        out_t ea;
        int n = 0;
        ia = {10'b1001000100, 12'($urandom), 5'($urandom), 5'($urandom_range(0, 30))};
        ib = {10'b1101000100, 12'($urandom), 5'($urandom), 5'($urandom_range(0, 30))};
        while (bus.instr_ready !== 1'b1 && n < 20) begin
            @(posedge clock); #1; n++;
        end
        model(ia, 4'h0);
        ea = exp_a[1];
        bus.instr_valid = 1'b1; bus.instr = ia; bus.status = 4'h0;
        @(posedge clock); #1; bus.instr = ib;
        @(posedge clock); #1;
        checks++;
        if (snap() !== ea) begin
            failures++; $display("FAIL b2b_exec_a got=%h exp=%h", snap(), ea);
        end
        @(posedge clock); #1;
        checks++;
        if ({bus.done, bus.instr_ready} !== 2'b10) begin
            failures++; $display("FAIL b2b_done got done=%b ready=%b exp done=1 ready=0", bus.done, bus.instr_ready);
        end
        @(posedge clock); #1;
        checks++;
        if ({bus.done, bus.instr_ready} !== 2'b01) begin
            failures++; $display("FAIL b2b_ready got done=%b ready=%b exp done=0 ready=1", bus.done, bus.instr_ready);
        end
        @(posedge clock); #1;
        model(ib, 4'h0);
        bus.instr_valid = 1'b0;
        checks++;
        if (bus.instr_ready !== 1'b0) begin
            failures++; $display("FAIL b2b_accept_b got ready=%b exp=0", bus.instr_ready);
        end
        @(posedge clock); #1;
        checks++;
        if (snap() !== exp_a[1]) begin
            failures++; $display("FAIL b2b_exec_b got=%h exp=%h", snap(), exp_a[1]);
        end
        repeat (2) begin @(posedge clock); #1; end
    endtask

    task automatic test_random();
        logic [10:0] tbl[10];
        logic [31:0] ins;
        logic [3:0]  st;
        int sel;
        tbl = '{11'b10001011000, 11'b10101011000, 11'b11001011000, 11'b11101011000,
                11'b10001010000, 11'b10101010000, 11'b11010011011, 11'b11010011010,
                11'b11111000010, 11'b11111000000};
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 13);
            if (sel < 10)       ins = {tbl[sel], 21'($urandom)};
            else if (sel == 10) ins = {10'b1001000100, 22'($urandom)};
            else if (sel == 11) ins = {10'b1101000100, 22'($urandom)};
            else                ins = $urandom;
            if ($urandom_range(0, 7) == 0) ins[4:0] = 5'd31;
            st = 4'($urandom);
            model(ins, st);
            issue(ins, st, 1'b0, "random");
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got_a[i] !== exp_a[i]) begin
                    failures++;
                    $display("FAIL random ins=%h cyc%0d got=%h exp=%h", ins, i, got_a[i], exp_a[i]);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_addi();
        test_subs_flags();
        test_ldur();
        test_stur_illegal();
        test_xzr_hold();
        test_back_to_back();
        test_reset_mid_mem();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports instr_valid (input, 1), instr (input, 32) and instr_ready (output, 1): valid/ready instruction handshake.
REQ-004 SHALL have port status, input, 4 bits: datapath flags {V,C,N,Z}, valid during EXEC.
REQ-005 SHALL have datapath control outputs: k (64), DA (5), SA (5), SB (5), FS (5), dataMux (1), regW (1), ramW (1), R (1), Bsel (1).
REQ-006 SHALL have outputs done (1), illegal (1) and flags (4): retire pulse, decode-error pulse, and the latched {V,C,N,Z}.
REQ-007 Datapath control meanings: dataMux 0=ALU / 1=RAM to register write; Bsel 1=k / 0=register B as ALU B operand; R=1 enables RAM read; ramW writes B to RAM[aluOut].
REQ-008 FS encoding: FS[4:2] op (000 AND, 001 ORR, 010 ADD, 011 XOR, 100 LSL, 101 LSR); FS[1] invert B; FS[0] carry-in; SUB = 01011.

Function
REQ-009 SHALL implement FSM states IDLE, DECODE, EXEC, MEM, DONE.
REQ-010 IDLE: instr_ready=1; instr_valid=1 latches instr and moves to DECODE; instr_ready=0 in every other state, and instr_valid is ignored while busy.
REQ-011 DECODE (1 cycle): classify the opcode; any opcode outside REQ-012 pulses illegal for 1 cycle and returns to IDLE without asserting regW, ramW or R.
REQ-012 Supported opcodes: R-type ADD 10001011000, ADDS 10101011000, SUB 11001011000, SUBS 11101011000, AND 10001010000, ORR 10101010000, LSL 11010011011, LSR 11010011010; I-type ADDI 1001000100, SUBI 1101000100; D-type LDUR 11111000010, STUR 11111000000.
REQ-013 Fields: Rd/Rt=instr[4:0], Rn=instr[9:5], Rm=instr[20:16], shamt=instr[15:10], imm12=instr[21:10], addr9=instr[20:12].
REQ-014 R-type ALU ops in EXEC: SA=Rn, SB=Rm, DA=Rd, Bsel=0, dataMux=0, regW=1, then DONE.
REQ-015 LSL/LSR in EXEC: SA=Rn, k=zero-extended shamt, Bsel=1, FS=100xx/101xx with FS[1:0]=00.
REQ-016 ADDI/SUBI in EXEC: k=zero-extended imm12, Bsel=1, SA=Rn, DA=Rd, regW=1.
REQ-017 LDUR: EXEC drives SA=Rn, k=sign-extended addr9, Bsel=1, FS=ADD, R=1, regW=0; MEM holds the same SA/k/FS/R with dataMux=1, DA=Rt, regW=1; then DONE.
REQ-018 STUR in EXEC: SA=Rn, SB=Rt, k=sign-extended addr9, Bsel=1, FS=ADD, ramW=1, regW=0; then DONE.
REQ-019 Destination 31 (XZR) SHALL force regW=0 for that instruction; the instruction still retires.
REQ-020 ADDS/SUBS SHALL load flags from status at the end of EXEC; all other instructions leave flags unchanged.
REQ-021 DONE: done=1 for exactly 1 cycle, all write enables 0, then IDLE.
REQ-022 Latency from the accept edge to the done pulse: 3 cycles for ALU ops and STUR, 4 cycles for LDUR.
REQ-023 Outside EXEC/MEM, regW, ramW, R, dataMux and Bsel SHALL be 0; k, DA, SA, SB and FS SHALL be 0 in IDLE.
REQ-024 Back-to-back: instr_ready SHALL rise in the cycle after done; there are no overlapping instructions.

Reset
REQ-025 reset_n=0 SHALL immediately force state IDLE, all outputs 0 (instr_ready=0 while in reset, 1 from the first cycle after release), flags=0 and the latched instr=0.
REQ-026 Reset mid-EXEC/MEM SHALL drop regW, ramW and R the same instant, so no write completes; the instruction is lost and done is not pulsed.

Verification
REQ-027 ADDI X1,X31,#5 (0x910017E1) -> EXEC: k=5, SA=31, DA=1, Bsel=1, FS=01000, regW=1; done 3 cycles after accept.
REQ-028 SUBS X3,X1,X2 with status=4'b0001 in EXEC -> FS=01011, SB=2, regW=1; flags=0001 after DONE; a following ADD leaves flags=0001.
REQ-029 LDUR X4,[X1,#-8] -> EXEC: k=0xFFFF_FFFF_FFFF_FFF8, R=1, regW=0; MEM: dataMux=1, DA=4, regW=1; done at cycle 4.
REQ-030 STUR X2,[X1,#0] then illegal 0xFFFFFFFF -> ramW=1 for exactly 1 cycle with SB=2; illegal pulses once, and no regW/ramW/R during the illegal instruction.
REQ-031 ADD X31,X1,X2 -> regW stays 0 and done pulses; instr_valid held high during busy cycles is not accepted twice.
REQ-032 reset_n low during LDUR MEM -> regW=0 and R=0 asynchronously, no done pulse; IDLE with instr_ready=1 after release.
